gesture_input_multi: RTL and testbench

Parametrised successor to the single-button gesture capture. It conditions NUM_BTN raw pushbuttons through synchronisers and per-button debounce, then classifies each press as short or long. On each event it emits the switch pattern that was latched at press time, as a one-cycle gesture plus button ID and long flag. It sits between the board I/O pins and the arm gesture decoder.

---
 rtl/gesture_input_multi.sv | 198 +++++++++++++++++++
 tb/tb_gesture_input_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_input_multi.sv
// gesture_input_multi
//   Conditions NUM_BTN raw pushbuttons and classifies each press as short or
//   long. The switch pattern present when a press is accepted is reported
//   with a one-cycle strobe, together with the button index and the long flag.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   button         raw asynchronous button pins (polarity set by ACTIVE_LOW)
//   sw             switch pattern sampled at press time
//   gesture        captured sw pattern, 0 when gesture_valid = 0
//   gesture_valid  one-cycle event strobe
//   gesture_btn    index of the button that produced the event, 0 when idle
//   gesture_long   1 = long press, 0 = short press, 0 when idle
//   btn_level      debounced pressed level per button (1 = pressed)
//
// Handshake: gesture_valid is a one-cycle strobe with no back-pressure.
// gesture, gesture_btn and gesture_long qualify it in the same cycle.
module gesture_input_multi #(
    parameter int NUM_BTN     = 4,
    parameter int GW          = 8,
    parameter int DEB_CYCLES  = 500000,
    parameter int HOLD_CYCLES = 25000000,
    parameter bit ACTIVE_LOW  = 1'b1,
    localparam int BW         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] button,
    input  logic [GW-1:0]      sw,
    output logic [GW-1:0]      gesture,
    output logic               gesture_valid,
    output logic [BW-1:0]      gesture_btn,
    output logic               gesture_long,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] REL_LVL = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    logic [NUM_BTN-1:0] sync1, sync2, pressed_sync;
    logic [NUM_BTN-1:0] pend, grant, ev_long, armed;
    logic [GW-1:0]      ev_sw [NUM_BTN];
    logic [BW-1:0]      sel;
    logic [1:0]         fill;
    logic               fill_done;

    // Synchronisers reset to the released level so a reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    assign pressed_sync = ACTIVE_LOW ? ~sync2 : sync2;

    // Two cycles after reset the synchroniser holds real pin data. A button
    // that is still pressed then was held across reset; it only becomes armed
    // once it has been seen released, so that press never produces an event.
    always_ff @(posedge clk) begin
        if (reset)              fill <= 2'd0;
        else if (fill != 2'd2)  fill <= fill + 2'd1;
    end

    assign fill_done = (fill == 2'd2);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        state_t          st_q, st_d;
        logic [DW-1:0]   deb_q;
        logic [HW-1:0]   hold_q;
        logic [GW-1:0]   cap_q, ev_sw_q;
        logic            lvl_q, pend_q, ev_long_q, armed_q;
        logic            hold_clr, hold_inc, cap_ld, ev_set, ev_lng;

        always_comb begin
            st_d     = st_q;
            hold_clr = 1'b0;
            hold_inc = 1'b0;
            cap_ld   = 1'b0;
            ev_set   = 1'b0;
            ev_lng   = 1'b0;
            case (st_q)
                IDLE: begin
                    if (lvl_q) begin
                        cap_ld   = 1'b1;
                        hold_clr = 1'b1;
                        // A press held across reset is parked in LONG, which
                        // waits for release without reporting anything.
                        st_d     = armed_q ? PRESSED : LONG;
                    end
                end
                PRESSED: begin
                    if (!lvl_q) begin
                        ev_set = 1'b1;
                        st_d   = IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        ev_set = 1'b1;
                        ev_lng = 1'b1;
                        st_d   = LONG;
                    end else begin
                        hold_inc = 1'b1;
                    end
                end
                LONG: begin
                    if (!lvl_q) st_d = IDLE;
                end
                default: st_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                st_q      <= IDLE;
                deb_q     <= '0;
                lvl_q     <= 1'b0;
                hold_q    <= '0;
                cap_q     <= '0;
                ev_sw_q   <= '0;
                ev_long_q <= 1'b0;
                pend_q    <= 1'b0;
                armed_q   <= 1'b0;
            end else begin
                st_q <= st_d;

                if (fill_done && !pressed_sync[i]) armed_q <= 1'b1;

                // Debounce: count consecutive mismatching cycles.
                if (pressed_sync[i] != lvl_q) begin
                    if (deb_q == DEB_LAST) begin
                        lvl_q <= ~lvl_q;
                        deb_q <= '0;
                    end else begin
                        deb_q <= deb_q + DW'(1);
                    end
                end else begin
                    deb_q <= '0;
                end

                // Hold counter only advances in PRESSED, so it stops at HOLD_LAST.
                if (hold_clr)      hold_q <= '0;
                else if (hold_inc) hold_q <= hold_q + HW'(1);

                if (cap_ld) cap_q <= sw;

                // A fresh event wins over a same-cycle grant so nothing is lost.
                if (ev_set) begin
                    pend_q    <= 1'b1;
                    ev_sw_q   <= cap_q;
                    ev_long_q <= ev_lng;
                end else if (grant[i]) begin
                    pend_q    <= 1'b0;
                end
            end
        end

        assign btn_level[i] = lvl_q;
        assign pend[i]      = pend_q;
        assign ev_long[i]   = ev_long_q;
        assign ev_sw[i]     = ev_sw_q;
        assign armed[i]     = armed_q;
    end

    // Fixed priority: lowest pending index is serviced first.
    always_comb begin
        grant = '0;
        sel   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (pend[i] && (grant == '0)) begin
                grant[i] = 1'b1;
                sel      = BW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (pend == '0)) begin
            gesture_valid <= 1'b0;
            gesture       <= '0;
            gesture_btn   <= '0;
            gesture_long  <= 1'b0;
        end else begin
            gesture_valid <= 1'b1;
            gesture       <= ev_sw[sel];
            gesture_btn   <= sel;
            gesture_long  <= ev_long[sel];
        end
    end

endmodule

// File: tb/tb_gesture_input_multi.sv
module tb_gesture_input_multi;

    localparam int NUM_BTN = 4;
    localparam int GW      = 8;
    localparam int DEB     = 4;
    localparam int HOLD    = 20;
    localparam int BW      = 2;

    // Clock / reset / DUT
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_BTN-1:0] button = '1;
    logic [GW-1:0]      sw = '0;
    logic [GW-1:0]      gesture;
    logic               gesture_valid;
    logic [BW-1:0]      gesture_btn;
    logic               gesture_long;
    logic [NUM_BTN-1:0] btn_level;

    always #5 clk = ~clk;

    gesture_input_multi #(
        .NUM_BTN(NUM_BTN), .GW(GW), .DEB_CYCLES(DEB),
        .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .sw(sw),
        .gesture(gesture), .gesture_valid(gesture_valid),
        .gesture_btn(gesture_btn), .gesture_long(gesture_long),
        .btn_level(btn_level)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: pin history, debounced level, press timing
    logic [BW+GW:0] exp_q[$];
    int             exp_t[$];
    int             cyc = 0;
    int             rst_edge = 0;
    logic           mlvl        [NUM_BTN];
    logic [5:0]     hist        [NUM_BTN];
    int             press_start [NUM_BTN];
    logic           press_ok    [NUM_BTN];
    logic           long_done   [NUM_BTN];
    logic           marm        [NUM_BTN];
    logic [GW-1:0]  msw         [NUM_BTN];

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                mlvl[i] = 1'b0; hist[i] = '0; press_start[i] = -1;
                press_ok[i] = 1'b0; long_done[i] = 1'b0; marm[i] = 1'b0; msw[i] = '0;
            end
            exp_q.delete();
            exp_t.delete();
            rst_edge = cyc;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                logic lvl_old, all_diff;
                lvl_old = mlvl[i];
                if (press_start[i] < 0) begin
                    if (lvl_old) begin
                        press_start[i] = cyc;
                        press_ok[i]    = marm[i];
                        long_done[i]   = 1'b0;
                        msw[i]         = sw;
                    end
                end else if (!lvl_old) begin
                    if (press_ok[i] && !long_done[i]) begin
                        exp_q.push_back({BW'(i), 1'b0, msw[i]});
                        exp_t.push_back(cyc);
                    end
                    press_start[i] = -1;
                end else if (press_ok[i] && !long_done[i] && (cyc - press_start[i] == HOLD)) begin
                    exp_q.push_back({BW'(i), 1'b1, msw[i]});
                    exp_t.push_back(cyc);
                    long_done[i] = 1'b1;
                end
                // Armed once the pin is seen released after the synchroniser refills.
                if ((cyc - rst_edge >= 3) && !hist[i][1]) marm[i] = 1'b1;
                // Level flips after DEB consecutive delayed samples disagree with it.
                all_diff = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (hist[i][j] == lvl_old) all_diff = 1'b0;
                if (all_diff) mlvl[i] = ~lvl_old;
                hist[i] = {hist[i][4:0], ~button[i]};
            end
        end
    end

    // Scoreboard / monitor
    logic [GW-1:0] mon_sw[$];
    logic [BW-1:0] mon_btn[$];
    logic          mon_long[$];
    int            mon_cyc[$];

    initial forever begin
        logic [NUM_BTN-1:0] lv;
        logic [BW+GW:0]     e;
        int                 t;
        @(negedge clk);
        for (int i = 0; i < NUM_BTN; i++) lv[i] = mlvl[i];
        chk("btn_level", btn_level, lv);
        if (gesture_valid) begin
            mon_sw.push_back(gesture);
            mon_btn.push_back(gesture_btn);
            mon_long.push_back(gesture_long);
            mon_cyc.push_back(cyc);
            chk("strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = exp_t.pop_front();
                chk("strobe_btn", gesture_btn, e[BW+GW:GW+1]);
                chk("strobe_long", gesture_long, e[GW]);
                chk("strobe_sw", gesture, e[GW-1:0]);
                chk("strobe_latency", (cyc - t >= 1) && (cyc - t <= NUM_BTN), 1);
            end
        end else begin
            chk("idle_outputs", {gesture, gesture_btn, gesture_long}, 0);
        end
    end

    // Driver
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        int last;

        // Reset state
        tick(3);
        chk("reset_valid", gesture_valid, 0);
        chk("reset_level", btn_level, 0);
        chk("reset_gesture", gesture, 0);
        reset = 1'b0;
        tick(100);
        chk("idle_strobes", mon_sw.size(), 0);
        chk("idle_level", btn_level, 0);

        // Short press on button 1, sw changes after capture
        sw = 8'hA5; button[1] = 1'b0; n = 0;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (btn_level[1]) begin n = j; break; end
        end
        chk("deb_latency", n, 6);
        tick(4);
        base = mon_sw.size();
        sw = 8'h3C; button[1] = 1'b1;
        tick(20);
        chk("short_count", mon_sw.size() - base, 1);
        last = mon_sw.size() - 1;
        chk("short_sw", mon_sw[last], 8'hA5);
        chk("short_btn", mon_btn[last], 1);
        chk("short_long", mon_long[last], 0);

        // Long press on button 2
        base = mon_sw.size();
        sw = 8'h81; button[2] = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (btn_level[2]) break;
        end
        n = 0;
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            if (gesture_valid) begin n = j; break; end
        end
        chk("long_latency", n, 22);
        tick(10);
        sw = 8'h00; button[2] = 1'b1;
        tick(20);
        chk("long_count", mon_sw.size() - base, 1);
        last = mon_sw.size() - 1;
        chk("long_sw", mon_sw[last], 8'h81);
        chk("long_btn", mon_btn[last], 2);
        chk("long_flag", mon_long[last], 1);

        // Glitches on button 0
        base = mon_sw.size();
        repeat (5) begin
            button[0] = 1'b0; tick(3);
            button[0] = 1'b1; tick(3);
        end
        tick(10);
        chk("glitch_count", mon_sw.size() - base, 0);
        chk("glitch_level", btn_level, 0);

        // Simultaneous release of buttons 0 and 3
        base = mon_sw.size();
        sw = 8'h11; button[0] = 1'b0;
        tick(8);
        sw = 8'h22; button[3] = 1'b0;
        tick(8);
        button[0] = 1'b1; button[3] = 1'b1;
        tick(15);
        chk("pair_count", mon_sw.size() - base, 2);
        if (mon_sw.size() - base == 2) begin
            chk("pair_first_btn", mon_btn[base], 0);
            chk("pair_first_sw", mon_sw[base], 8'h11);
            chk("pair_second_btn", mon_btn[base+1], 3);
            chk("pair_second_sw", mon_sw[base+1], 8'h22);
            chk("pair_gap", mon_cyc[base+1] - mon_cyc[base], 1);
        end

        // Reset mid-press on button 1
        base = mon_sw.size();
        sw = 8'h77; button[1] = 1'b0;
        tick(10);
        reset = 1'b1; tick(2); reset = 1'b0;
        tick(20);
        button[1] = 1'b1;
        tick(20);
        chk("rst_press_count", mon_sw.size() - base, 0);
        chk("rst_press_level", btn_level, 0);
        sw = 8'h5A; button[1] = 1'b0;
        tick(10);
        sw = 8'h00; button[1] = 1'b1;
        tick(15);
        chk("fresh_count", mon_sw.size() - base, 1);
        last = mon_sw.size() - 1;
        chk("fresh_sw", mon_sw[last], 8'h5A);
        chk("fresh_btn", mon_btn[last], 1);
        chk("fresh_long", mon_long[last], 0);

        tick(5);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
